// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its memory-side blocks.
//  - CPU_AW / CPU_DW : default address and data widths used by the CPU, PC, MAR and M
//  - state_t         : prog_loader_mem sequencing states
package cpu_pkg;

  localparam int CPU_AW = 4;
  localparam int CPU_DW = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW register file with one synchronous write port and one
// asynchronous read port. The storage has no reset; its owner initialises it.
// Ports:
//  clk       in  clock
//  i_we      in  write enable
//  i_waddr   in  write address
//  i_wdata   in  write data
//  i_raddr   in  read address
//  o_rdata   out combinational read data for i_raddr
module mem_array #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Memory-side responder for the accumulator CPU. Serves CPU reads/writes from a
// 16x8 array, and lets a host stream a full program image into the array while
// the CPU is held in reset. After reset the array is cleared to FILL, then the
// CPU is released.
//
// Handshakes:
//  host byte : transferred on a rising edge where ld_valid && ld_ready; ld_data
//              must be stable while ld_valid is high. ld_ready is only high in
//              LOAD, so no byte is ever lost or duplicated.
//  cpu read  : cpu_rd at an edge -> cpu_rvalid high for exactly the next cycle
//              with cpu_rdata valid in that same cycle; no backpressure.
//
// Ports:
//  clk, RESET          clock, synchronous active-low reset
//  ld_start            request a program load (honoured only in RUN)
//  ld_valid/ld_data    host byte stream, address 0 first
//  ld_ready            host byte may be accepted
//  ld_done             one-cycle pulse after the last image byte
//  cpu_rst_n           CPU reset, high only while in RUN
//  cpu_addr/rd/wr/wdata CPU memory request
//  cpu_rdata/rvalid    registered read response
//  dbg_state           current sequencing state, for observation
module prog_loader_mem
  import cpu_pkg::*;
#(
  parameter int            AW   = CPU_AW,
  parameter int            DW   = CPU_DW,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          cpu_rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output state_t        dbg_state
);

  // Last word address; sequences end here explicitly rather than by wrapping.
  localparam logic [AW-1:0] LAST = '1;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ld_ready;
  logic          r_ld_done;
  logic          r_cpu_rst_n;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_mem_rdata;

  // Single write port, owned by exactly one source per state. Nothing is
  // written while RESET is asserted, and a CPU write coinciding with
  // ld_start is dropped because the load takes priority.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = FILL;
    if (RESET) begin
      case (r_state)
        ST_CLEAR: begin
          w_we = 1'b1;
        end
        ST_LOAD: begin
          w_we    = ld_valid && r_ld_ready;
          w_wdata = ld_data;
        end
        ST_RUN: begin
          w_we    = cpu_wr && !ld_start;
          w_waddr = cpu_addr;
          w_wdata = cpu_wdata;
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (cpu_addr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= '0;
      r_ld_ready  <= 1'b0;
      r_ld_done   <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      r_rvalid  <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (ld_start) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_ld_ready  <= 1'b1;
            r_cpu_rst_n <= 1'b0;
          end else if (cpu_rd) begin
            r_rvalid <= 1'b1;
            // Write-first: a same-cycle write returns the new data.
            r_rdata  <= cpu_wr ? cpu_wdata : w_mem_rdata;
          end
        end
        ST_LOAD: begin
          if (ld_valid && r_ld_ready) begin
            if (r_cnt == LAST) begin
              r_cnt       <= '0;
              r_ld_ready  <= 1'b0;
              r_ld_done   <= 1'b1;
              r_cpu_rst_n <= 1'b1;
              r_state     <= ST_RUN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_cnt       <= '0;
          r_ld_ready  <= 1'b0;
          r_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready   = r_ld_ready;
  assign ld_done    = r_ld_done;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_prog_loader_mem.sv
module tb_prog_loader_mem;
  import cpu_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic       ld_done;
  logic       cpu_rst_n;
  logic [3:0] cpu_addr = 4'h0;
  logic       cpu_rd = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  state_t     dbg_state;

  always #5 clk = ~clk;

  prog_loader_mem #(.AW(4), .DW(8), .FILL(8'h00)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_state  (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks: remaining clear cycles, whether a load is in progress and how many
  // image bytes have arrived, plus a plain copy of the memory contents.
  logic [7:0] m_mem [DEPTH];
  int         m_clear_left = 0;
  bit         m_loading = 0;
  int         m_idx = 0;
  logic       e_rst_n = 0, e_ready = 0, e_done = 0, e_rvalid = 0;
  logic [7:0] e_rdata = 8'h00;
  logic [7:0] exp_q[$];

  task automatic model_edge();
    e_done   = 0;
    e_rvalid = 0;
    if (!RESET) begin
      m_clear_left = DEPTH;
      m_loading    = 0;
      e_rst_n      = 0;
      e_ready      = 0;
      e_rdata      = 8'h00;
    end else if (m_clear_left > 0) begin
      m_mem[DEPTH - m_clear_left] = 8'h00;
      m_clear_left--;
      e_rst_n = (m_clear_left == 0);
    end else if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_idx] = ld_data;
        m_idx++;
        if (m_idx == DEPTH) begin
          m_loading = 0;
          e_done    = 1;
          e_ready   = 0;
          e_rst_n   = 1;
        end
      end
    end else if (ld_start) begin
      m_loading = 1;
      m_idx     = 0;
      e_ready   = 1;
      e_rst_n   = 0;
    end else begin
      if (cpu_wr) m_mem[cpu_addr] = cpu_wdata;
      if (cpu_rd) begin
        e_rvalid = 1;
        e_rdata  = m_mem[cpu_addr];
        exp_q.push_back(e_rdata);
      end
    end
  endtask

  // ---------------- driver: one clock, model, compare ----------------
  task automatic step();
    logic [7:0] exp_d;
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_rst_n", cpu_rst_n, e_rst_n);
    check("ld_ready", ld_ready, e_ready);
    check("ld_done", ld_done, e_done);
    check("cpu_rvalid", cpu_rvalid, e_rvalid);
    check("cpu_rdata", cpu_rdata, e_rdata);
    if (cpu_rvalid === 1'b1) begin
      check("sb_response_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        check("sb_rdata", cpu_rdata, exp_d);
      end
    end
  endtask

  logic [7:0] img [DEPTH];

  task automatic read_check(input bit use_img, input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      cpu_rd   = 1;
      cpu_wr   = 0;
      cpu_addr = 4'(a);
      step();
      check(tag, cpu_rdata, use_img ? img[a] : 8'h00);
    end
    cpu_rd = 0;
    step();
  endtask

  // mode 0: ld_valid always 1, 1: toggles starting at 1, 2: random
  task automatic load_image(input bit do_start, input int mode, input int n_bytes,
                            input bit noise, output int cycles, output int dones);
    int acc;
    acc    = 0;
    cycles = 0;
    dones  = 0;
    if (do_start) begin
      ld_start = 1;
      step();
      ld_start = 0;
    end
    while (acc < n_bytes && cycles < 200) begin
      case (mode)
        0:       ld_valid = 1;
        1:       ld_valid = (cycles % 2 == 0);
        default: ld_valid = 1'($urandom_range(0, 1));
      endcase
      ld_data = img[acc];
      if (noise) begin
        cpu_rd    = 1'($urandom_range(0, 1));
        cpu_wr    = 1'($urandom_range(0, 1));
        cpu_addr  = 4'($urandom);
        cpu_wdata = 8'($urandom);
      end
      if (ld_valid && ld_ready) acc++;
      step();
      cycles++;
      if (ld_done) dones++;
    end
    ld_valid = 0;
    cpu_rd   = 0;
    cpu_wr   = 0;
    check("load_bytes_accepted", acc, n_bytes);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt, cyc, dn;

    // Applied after the 8'h10..8'h1F image is loaded.
    vecs[0] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 8'h13};
    vecs[1] = '{1'b1, 1'b1, 4'hA, 8'h5C, 1'b1, 8'h5C};  // write-first
    vecs[2] = '{1'b1, 1'b0, 4'hA, 8'h00, 1'b1, 8'h5C};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h5C};  // rdata holds
    vecs[4] = '{1'b0, 1'b1, 4'h0, 8'hAA, 1'b0, 8'h5C};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'hAA};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 8'h00, 1'b1, 8'h1F};
    vecs[7] = '{1'b1, 1'b0, 4'h9, 8'h00, 1'b1, 8'h19};

    // ---- 1: reset, clear length, cleared contents ----
    RESET = 0;
    step();
    step();
    RESET = 1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (cpu_rst_n !== 1'b1 && cnt < 40);
    check("clear_cycles", cnt, 16);
    read_check(0, "t1_cleared");

    // ---- 2: streaming load, ld_valid always 1 ----
    for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'h10 + i);
    load_image(1, 0, DEPTH, 0, cyc, dn);
    check("t2_done_count", dn, 1);
    check("t2_done_after_last", ld_done, 1);
    check("t2_cycles", cyc, 16);
    step();
    check("t2_done_single", ld_done, 0);
    read_check(1, "t2_image");

    // ---- table vectors in RUN ----
    for (int v = 0; v < 8; v++) begin
      cpu_rd    = vecs[v].rd;
      cpu_wr    = vecs[v].wr;
      cpu_addr  = vecs[v].addr;
      cpu_wdata = vecs[v].wdata;
      step();
      check("vec_rvalid", cpu_rvalid, vecs[v].exp_rvalid);
      check("vec_rdata", cpu_rdata, vecs[v].exp_rdata);
    end
    cpu_rd = 0;
    cpu_wr = 0;
    step();

    // ---- 3: ld_valid toggling; bytes land on cycles 1,3,..,31 ----
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    load_image(1, 1, DEPTH, 0, cyc, dn);
    check("t3_cycles", cyc, 31);
    check("t3_done_count", dn, 1);
    step();
    read_check(1, "t3_image");

    // ---- 4: CPU strobes during LOAD are ignored ----
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    load_image(1, 2, DEPTH, 1, cyc, dn);
    check("t4_done_count", dn, 1);
    step();
    read_check(1, "t4_image");

    // ---- 5: reset in the middle of a load ----
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(1, 255));
    load_image(1, 0, 7, 0, cyc, dn);
    RESET = 0;
    step();
    check("t5_ready_in_reset", ld_ready, 0);
    RESET = 1;
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ld_done) dn++;
      check("t5_ready_clear", ld_ready, 0);
    end
    check("t5_no_done", dn, 0);
    check("t5_run", cpu_rst_n, 1);
    read_check(0, "t5_cleared");

    // ---- 6: ld_start held through CLEAR ----
    ld_start = 1;
    RESET = 0;
    step();
    RESET = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("t6_ignored_in_clear", ld_ready, 0);
    end
    check("t6_first_run", cpu_rst_n, 1);
    step();
    check("t6_enter_load", ld_ready, 1);
    check("t6_cpu_held", cpu_rst_n, 0);
    ld_start = 0;
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    load_image(0, 2, DEPTH, 0, cyc, dn);
    check("t6_done_count", dn, 1);
    step();
    read_check(1, "t6_image");

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 500; c++) begin
      RESET     = ($urandom_range(0, 199) != 0);
      ld_start  = ($urandom_range(0, 24) == 0);
      ld_valid  = 1'($urandom_range(0, 1));
      ld_data   = 8'($urandom);
      cpu_rd    = 1'($urandom_range(0, 1));
      cpu_wr    = ($urandom_range(0, 2) == 0);
      cpu_addr  = 4'($urandom);
      cpu_wdata = 8'($urandom);
      step();
    end
    RESET    = 1;
    ld_start = 0;
    ld_valid = 0;
    cpu_rd   = 0;
    cpu_wr   = 0;
    step();
    step();
    check("sb_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
